if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/common_param.sv | 16 +
 rtl/if_prefetch_if.sv | 36 +++
 rtl/fetch_queue.sv | 53 +++++
 rtl/if_prefetch.sv | 86 ++++++++
 tb/tb_if_prefetch.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/common_param.sv
// Shared codebase parameters.
// Purpose : single home for memory-size and reset-vector defaults used by the
//           fetch front end and any other block sizing against instruction memory.
// Contents: IMEM_SIZE (bytes), IMEM_DEPTH_DEF (words), RESET_PC_DEF (byte address).
package common_param;

    // Instruction memory size in bytes.
    localparam int IMEM_SIZE = 256;

    // Instruction memory depth in 32-bit words; must stay a power of 2.
    localparam int IMEM_DEPTH_DEF = IMEM_SIZE / 4;

    // Fetch PC after reset; word-aligned.
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/if_prefetch_if.sv
// Bus bundle of the instruction prefetch unit.
// Purpose : groups program-load, redirect and delivery handshake signals.
// Signals : WE/W_Addr/W_Ins  - instruction memory write (program load)
//           bout/newPC       - redirect request and target
//           Ready/Valid      - head-of-queue handshake
//           Ins/PC/nextPC    - head instruction, its PC, and PC+4
//           Count            - fetch-queue occupancy
// Modports: master drives requests (bench/upstream), slave is the prefetch unit.
interface if_prefetch_if #(
    parameter int XLEN     = 32,
    parameter int FQ_DEPTH = 4
);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    logic             WE;
    logic [XLEN-1:0]  W_Addr;
    logic [XLEN-1:0]  W_Ins;
    logic [1:0]       bout;
    logic [XLEN-1:0]  newPC;
    logic             Ready;
    logic             Valid;
    logic [XLEN-1:0]  Ins;
    logic [XLEN-1:0]  PC;
    logic [XLEN-1:0]  nextPC;
    logic [CNT_W-1:0] Count;

    modport master (
        output WE, W_Addr, W_Ins, bout, newPC, Ready,
        input  Valid, Ins, PC, nextPC, Count
    );

    modport slave (
        input  WE, W_Addr, W_Ins, bout, newPC, Ready,
        output Valid, Ins, PC, nextPC, Count
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: power-of-2 circular FIFO of {PC, instruction} entries.
// Ports: CLK, RST (sync, active-high), push/pop/flush controls, din write
//        data, dout head data (registered storage, so it changes only at edges),
//        full/empty flags and count occupancy.
// The caller must not push when full without a same-cycle pop, nor pop when empty.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit.
// Purpose : fetches from a local instruction memory at fPC into a FIFO,
//           delivering one instruction per cycle under a Valid/Ready handshake,
//           with branch redirect and program-load write port.
// Ports   : CLK, RST (sync, active-high), bus (if_prefetch_if.slave):
//           WE/W_Addr/W_Ins load IMem; bout/newPC redirect; Ready accepts head;
//           Valid/Ins/PC/nextPC/Count describe the queue head and occupancy.
module if_prefetch
    import common_param::*;
#(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int              FQ_DEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF)
) (
    input  logic          CLK,
    input  logic          RST,
    if_prefetch_if.slave  bus
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    logic [XLEN-1:0]   fpc;
    logic [XLEN-1:0]   imem [IMEM_DEPTH];
    logic [XLEN-1:0]   fetch_ins;
    logic              redirect;
    logic              push;
    logic              pop;
    logic              q_full;
    logic              q_empty;
    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0]   head_pc;
    logic              unused_bits;

    assign redirect = |bus.bout;

    // Word index ignores upper address bits, so fetch wraps around IMem.
    assign fetch_ins = imem[fpc[IDX_W+1:2]];

    // Redirect suppresses both queue operations; a pop frees a slot for a
    // same-cycle push so a full queue still streams at one per cycle.
    assign pop  = !RST && !redirect && !q_empty && bus.Ready;
    assign push = !RST && !redirect && (!q_full || pop);

    fetch_queue #(
        .WIDTH (2*XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({fpc, fetch_ins}),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (bus.Count)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            fpc <= RESET_PC;
        else if (redirect)
            fpc <= {bus.newPC[XLEN-1:2], 2'b00};
        else if (push)
            fpc <= fpc + XLEN'(4);
    end

    // Write lands at the edge; the combinational fetch in the same cycle
    // therefore still sees the old word.
    always_ff @(posedge CLK) begin
        if (bus.WE && !RST)
            imem[bus.W_Addr[IDX_W+1:2]] <= bus.W_Ins;
    end

    assign head_pc    = q_empty ? fpc : head[2*XLEN-1:XLEN];
    assign bus.Valid  = !q_empty;
    assign bus.Ins    = q_empty ? '0 : head[XLEN-1:0];
    assign bus.PC     = head_pc;
    assign bus.nextPC = head_pc + XLEN'(4);

    // Byte-offset and out-of-range address bits carry no meaning here.
    assign unused_bits = ^{bus.W_Addr, bus.newPC[1:0]};

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;

    localparam int XLEN       = 32;
    localparam int IMEM_DEPTH = 64;
    localparam int FQ_DEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    if_prefetch_if #(.XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH)) bus ();

    if_prefetch #(
        .XLEN       (XLEN),
        .IMEM_DEPTH (IMEM_DEPTH),
        .FQ_DEPTH   (FQ_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    // Behavioural reference: a queue of {pc, ins} records, a fetch PC and a memory.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mfpc;
    logic [31:0] mmem [IMEM_DEPTH];

    typedef struct {
        logic        rst;
        logic [1:0]  bout;
        logic [31:0] newpc;
        logic        ready;
        logic        ev;
        logic [31:0] eins;
        logic [31:0] epc;
        int          ecnt;
    } vec_t;

    localparam int NV = 23;
    vec_t tv [NV];

    function automatic vec_t mk(logic rst, logic [1:0] bout, logic [31:0] newpc, logic ready,
                                logic ev, logic [31:0] eins, logic [31:0] epc, int ecnt);
        vec_t v;
        v.rst = rst; v.bout = bout; v.newpc = newpc; v.ready = ready;
        v.ev = ev; v.eins = eins; v.epc = epc; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [31:0] waddr,
                         input logic [31:0] wins, input logic [1:0] bout,
                         input logic [31:0] newpc, input logic ready);
        RST        = rst;
        bus.WE     = we;
        bus.W_Addr = waddr;
        bus.W_Ins  = wins;
        bus.bout   = bout;
        bus.newPC  = newpc;
        bus.Ready  = ready;
    endtask

    // Apply the architectural rules for one clock edge to the model.
    task automatic model_edge();
        logic [31:0] fetched;
        int          idx;
        if (RST) begin
            mq.delete();
            mfpc = RESET_PC;
        end else begin
            idx     = int'((mfpc >> 2) % IMEM_DEPTH);
            fetched = mmem[idx];
            if (bus.bout != 2'b00) begin
                mq.delete();
                mfpc = bus.newPC & ~32'h3;
            end else begin
                if (mq.size() > 0 && bus.Ready) void'(mq.pop_front());
                if (mq.size() < FQ_DEPTH) begin
                    mq.push_back('{pc: mfpc, ins: fetched});
                    mfpc = mfpc + 32'd4;
                end
            end
            if (bus.WE) mmem[int'((bus.W_Addr >> 2) % IMEM_DEPTH)] = bus.W_Ins;
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] epc;
        logic [31:0] eins;
        logic        ev;
        ev   = (mq.size() > 0);
        epc  = ev ? mq[0].pc  : mfpc;
        eins = ev ? mq[0].ins : 32'h0;
        chk({tag, " Valid"},  32'(bus.Valid), 32'(ev));
        chk({tag, " Ins"},    bus.Ins,        eins);
        chk({tag, " PC"},     bus.PC,         epc);
        chk({tag, " nextPC"}, bus.nextPC,     epc + 32'd4);
        chk({tag, " Count"},  32'(bus.Count), 32'(mq.size()));
    endtask

    task automatic cycle(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        if (model_on) check_model(tag);
    endtask

    initial begin
        // Expected values below are hand-derived: IMem[i] = 0x11*(i+1).
        tv[0]  = mk(1, 2'b00, 0, 1, 0, 32'h00, 32'h00, 0);
        tv[1]  = mk(0, 2'b00, 0, 1, 1, 32'h11, 32'h00, 1);
        tv[2]  = mk(0, 2'b00, 0, 1, 1, 32'h22, 32'h04, 1);
        tv[3]  = mk(0, 2'b00, 0, 1, 1, 32'h33, 32'h08, 1);
        tv[4]  = mk(0, 2'b00, 0, 1, 1, 32'h44, 32'h0C, 1);
        tv[5]  = mk(1, 2'b00, 0, 0, 0, 32'h00, 32'h00, 0);
        tv[6]  = mk(0, 2'b00, 0, 0, 1, 32'h11, 32'h00, 1);
        tv[7]  = mk(0, 2'b00, 0, 0, 1, 32'h11, 32'h00, 2);
        tv[8]  = mk(0, 2'b00, 0, 0, 1, 32'h11, 32'h00, 3);
        tv[9]  = mk(0, 2'b00, 0, 0, 1, 32'h11, 32'h00, 4);
        tv[10] = mk(0, 2'b00, 0, 0, 1, 32'h11, 32'h00, 4);
        tv[11] = mk(0, 2'b00, 0, 0, 1, 32'h11, 32'h00, 4);
        tv[12] = mk(0, 2'b00, 0, 1, 1, 32'h22, 32'h04, 4);
        tv[13] = mk(0, 2'b00, 0, 1, 1, 32'h33, 32'h08, 4);
        tv[14] = mk(0, 2'b00, 0, 1, 1, 32'h44, 32'h0C, 4);
        tv[15] = mk(0, 2'b00, 0, 1, 1, 32'h55, 32'h10, 4);
        tv[16] = mk(0, 2'b00, 0, 1, 1, 32'h66, 32'h14, 4);
        tv[17] = mk(1, 2'b00, 0, 0, 0, 32'h00, 32'h00, 0);
        tv[18] = mk(0, 2'b00, 0, 0, 1, 32'h11, 32'h00, 1);
        tv[19] = mk(0, 2'b00, 0, 0, 1, 32'h11, 32'h00, 2);
        tv[20] = mk(0, 2'b00, 0, 0, 1, 32'h11, 32'h00, 3);
        tv[21] = mk(0, 2'b01, 32'h22, 1, 0, 32'h00, 32'h20, 0);
        tv[22] = mk(0, 2'b00, 0, 0, 1, 32'h99, 32'h20, 1);

        for (int i = 0; i < IMEM_DEPTH; i++) mmem[i] = 'x;
        mfpc = 'x;

        // Program load (queue contents during this phase are not checked).
        drive(1, 0, 0, 0, 2'b00, 0, 0);
        cycle("reset0");
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            drive(0, 1, 32'(i * 4), 32'(32'h11 * (i + 1)), 2'b00, 0, 0);
            cycle("load");
        end

        // Directed table.
        model_on = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tv[i].rst, 0, 0, 0, tv[i].bout, tv[i].newpc, tv[i].ready);
            cycle($sformatf("vec%0d model", i));
            chk($sformatf("vec%0d Valid", i),  32'(bus.Valid), 32'(tv[i].ev));
            chk($sformatf("vec%0d Ins", i),    bus.Ins,        tv[i].eins);
            chk($sformatf("vec%0d PC", i),     bus.PC,         tv[i].epc);
            chk($sformatf("vec%0d nextPC", i), bus.nextPC,     tv[i].epc + 32'd4);
            chk($sformatf("vec%0d Count", i),  32'(bus.Count), 32'(tv[i].ecnt));
        end

        // Same-cycle write at the fetch address returns the old word.
        drive(1, 0, 0, 0, 2'b00, 0, 0);        cycle("rbw rst");
        drive(0, 0, 0, 0, 2'b00, 0, 0);        cycle("rbw f0");
        cycle("rbw f4");
        drive(0, 1, 32'h8, 32'hDEAD, 2'b00, 0, 0); cycle("rbw wr");
        drive(0, 0, 0, 0, 2'b00, 0, 1);        cycle("rbw p1");
        cycle("rbw p2");
        chk("rbw old PC",  bus.PC,  32'h8);
        chk("rbw old Ins", bus.Ins, 32'h33);
        drive(0, 0, 0, 0, 2'b10, 32'h8, 1);    cycle("rbw redir");
        chk("rbw redir Valid", 32'(bus.Valid), 32'h0);
        drive(0, 0, 0, 0, 2'b00, 0, 0);        cycle("rbw new");
        chk("rbw new Ins", bus.Ins, 32'hDEAD);

        // Reset beats a simultaneous redirect and write.
        drive(0, 0, 0, 0, 2'b00, 0, 1);
        for (int i = 0; i < 3; i++) cycle("stream");
        drive(1, 1, 32'h0, 32'hBAD, 2'b01, 32'h40, 1); cycle("rst+redir");
        chk("rst+redir Count", 32'(bus.Count), 32'h0);
        chk("rst+redir PC",    bus.PC,         RESET_PC);
        chk("rst+redir Valid", 32'(bus.Valid), 32'h0);
        drive(0, 0, 0, 0, 2'b00, 0, 1);        cycle("after rst");
        chk("rst WE ignored Ins", bus.Ins, 32'h11);

        // Index wrap and PC wrap.
        drive(0, 0, 0, 0, 2'b01, 32'hFC, 0);   cycle("wrap redir");
        drive(0, 0, 0, 0, 2'b00, 0, 0);        cycle("wrap head");
        chk("wrap top Ins",    bus.Ins,    32'h440);
        chk("wrap top nextPC", bus.nextPC, 32'h100);
        drive(0, 0, 0, 0, 2'b00, 0, 1);        cycle("wrap step");
        chk("wrap idx PC",  bus.PC,  32'h100);
        chk("wrap idx Ins", bus.Ins, 32'h11);
        drive(0, 0, 0, 0, 2'b11, 32'hFFFF_FFFE, 1); cycle("pcwrap redir");
        drive(0, 0, 0, 0, 2'b00, 0, 0);        cycle("pcwrap head");
        chk("pcwrap PC",     bus.PC,     32'hFFFF_FFFC);
        chk("pcwrap nextPC", bus.nextPC, 32'h0);
        drive(0, 0, 0, 0, 2'b00, 0, 1);        cycle("pcwrap step");
        chk("pcwrap next PC",  bus.PC,  32'h0);
        chk("pcwrap next Ins", bus.Ins, 32'h11);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(99) < 2,
                  $urandom_range(99) < 10,
                  32'($urandom_range(IMEM_DEPTH * 4 - 1)),
                  $urandom,
                  ($urandom_range(99) < 10) ? 2'($urandom_range(3, 1)) : 2'b00,
                  $urandom,
                  $urandom_range(99) < 60);
            cycle($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
